// File: rtl/proc_instr_sequencer_pkg.sv
// proc_instr_sequencer_pkg: instruction-word field layout and sequencer state encoding
package proc_instr_sequencer_pkg;
  localparam int WORD_W = 18;
  localparam int CAP_BIT = 17;
  localparam int FUNC_HI = 16;
  localparam int FUNC_LO = 8;
  localparam int DATA_HI = 7;
  localparam int OP_HI = 16;
  localparam int OP_LO = 14;
  localparam int RX_HI = 13;
  localparam int RX_LO = 11;
  localparam int RY_HI = 10;
  localparam int RY_LO = 8;
  typedef logic [WORD_W-1:0] word_t;
  typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} seq_state_t;
  function automatic logic [2:0] opcode(input word_t w);
    return w[OP_HI:OP_LO];
  endfunction
endpackage

// File: rtl/proc_instr_sequencer_seq_prog_mem.sv
// seq_prog_mem: program store with synchronous write and combinational read, no reset
module seq_prog_mem
  import proc_instr_sequencer_pkg::*;
#(
  parameter int AW = 4
) (
  input  logic          clock,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  word_t         wdata,
  input  logic [AW-1:0] raddr,
  output word_t         rdata
);
  word_t mem [2**AW];
  always_ff @(posedge clock)
    if (we) mem[waddr] <= wdata;
  assign rdata = mem[raddr];
endmodule

// File: rtl/proc_instr_sequencer.sv
// proc_instr_sequencer: issues a loaded program onto the processor func/dataIn bus and captures dataOut
module proc_instr_sequencer
  import proc_instr_sequencer_pkg::*;
#(
  parameter int         AW          = 4,
  parameter int         CAPTURE_LAT = 1,
  parameter logic [8:0] IDLE_FUNC   = 9'h000
) (
  input  logic          clock,
  input  logic          reset,
  input  logic          load_en,
  input  logic [AW-1:0] load_addr,
  input  word_t         load_word,
  input  logic          start,
  input  logic [AW:0]   length,
  input  logic [7:0]    proc_data_out,
  output logic [8:0]    func,
  output logic [7:0]    proc_data_in,
  output logic          busy,
  output logic          done,
  output logic [7:0]    result,
  output logic          result_valid
);
  localparam int DEPTH = 2**AW;
  localparam logic [AW:0] DEPTH_W = (AW+1)'(DEPTH);
  localparam logic [2:0] DRAIN_LAST = 3'(CAPTURE_LAT-1);
  seq_state_t state;
  logic [AW:0] pc, len, len_c;
  logic [2:0] dcnt;
  logic [CAPTURE_LAT-1:0] pipe;
  logic [CAPTURE_LAT:0] pipe_ext;
  logic issue_cap;
  word_t rd_word;
  seq_prog_mem #(.AW(AW)) u_mem (
    .clock(clock),
    .we(load_en && state == IDLE),
    .waddr(load_addr),
    .wdata(load_word),
    .raddr(pc[AW-1:0]),
    .rdata(rd_word)
  );
  assign len_c = length > DEPTH_W ? DEPTH_W : length;
  assign issue_cap = state == RUN && rd_word[CAP_BIT];
  // widened by one bit so the shift is legal even for a single-stage pipeline
  assign pipe_ext = {pipe, issue_cap};
  always_ff @(posedge clock) begin
    if (reset) begin
      state <= IDLE;
      pc <= '0;
      len <= '0;
      dcnt <= '0;
      pipe <= '0;
      func <= IDLE_FUNC;
      proc_data_in <= '0;
      busy <= 1'b0;
      done <= 1'b0;
      result <= '0;
      result_valid <= 1'b0;
    end else begin
      pipe <= pipe_ext[CAPTURE_LAT-1:0];
      result_valid <= pipe[CAPTURE_LAT-1];
      if (pipe[CAPTURE_LAT-1]) result <= proc_data_out;
      func <= state == RUN ? rd_word[FUNC_HI:FUNC_LO] : IDLE_FUNC;
      proc_data_in <= state == RUN ? rd_word[DATA_HI:0] : '0;
      busy <= 1'b0;
      done <= 1'b0;
      case (state)
        IDLE: if (start) begin
          pc <= '0;
          len <= len_c;
          state <= len_c == '0 ? DONE : RUN;
          busy <= len_c != '0;
          done <= len_c == '0;
        end
        RUN: begin
          pc <= pc + 1'b1;
          busy <= 1'b1;
          dcnt <= '0;
          if (pc + 1'b1 == len) state <= DRAIN;
        end
        DRAIN: begin
          busy <= dcnt != DRAIN_LAST;
          done <= dcnt == DRAIN_LAST;
          if (dcnt == DRAIN_LAST) state <= DONE;
          else dcnt <= dcnt + 1'b1;
        end
        DONE: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_proc_instr_sequencer.sv
// tb_proc_instr_sequencer: directed checks of issue timing, capture, clamping, load gating and reset abort
module tb_proc_instr_sequencer;
  logic clock = 1'b0;
  logic reset = 1'b1;
  logic load_en = 1'b0;
  logic [3:0] load_addr = '0;
  logic [17:0] load_word = '0;
  logic start = 1'b0;
  logic [4:0] length = '0;
  logic [7:0] proc_data_out = '0;
  logic [8:0] func;
  logic [7:0] proc_data_in;
  logic busy, done, result_valid;
  logic [7:0] result;
  int vectors = 0;
  int miscompares = 0;
  int issues, captures;
  logic saw_done;

  always #5 clock = ~clock;

  proc_instr_sequencer dut (
    .clock(clock), .reset(reset), .load_en(load_en), .load_addr(load_addr),
    .load_word(load_word), .start(start), .length(length),
    .proc_data_out(proc_data_out), .func(func), .proc_data_in(proc_data_in),
    .busy(busy), .done(done), .result(result), .result_valid(result_valid)
  );

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic load(input logic [3:0] a, input logic [17:0] w);
    load_en = 1'b1;
    load_addr = a;
    load_word = w;
    tick();
    load_en = 1'b0;
  endtask

  initial begin
    tick();
    tick();
    reset = 1'b0;
    check("rst_func", 32'(func), 32'h000);
    check("rst_busy", 32'(busy), 32'h0);
    // activity before a reset: leave a captured result behind
    load(4'd0, {1'b1, 9'o045, 8'h11});
    proc_data_out = 8'h77;
    start = 1'b1; length = 5'd1;
    tick();
    start = 1'b0;
    tick();
    tick();
    check("pre_result", 32'(result), 32'h77);
    check("pre_done", 32'(done), 32'h1);
    tick();
    reset = 1'b1;
    tick();
    check("reset_func", 32'(func), 32'h000);
    check("reset_pdi", 32'(proc_data_in), 32'h00);
    check("reset_busy", 32'(busy), 32'h0);
    check("reset_done", 32'(done), 32'h0);
    check("reset_result", 32'(result), 32'h00);
    check("reset_rv", 32'(result_valid), 32'h0);
    reset = 1'b0;
    start = 1'b1; length = 5'd1;
    tick();
    start = 1'b0;
    tick();
    check("kept_func", 32'(func), 32'(9'o045));
    check("kept_pdi", 32'(proc_data_in), 32'h11);
    tick();
    tick();
    // three-word program, last word captured
    load(4'd0, {1'b0, 9'o123, 8'h5A});
    load(4'd1, {1'b0, 9'o210, 8'h00});
    load(4'd2, {1'b1, 9'o301, 8'h00});
    proc_data_out = 8'hC3;
    start = 1'b1; length = 5'd3;
    tick();
    start = 1'b0;
    check("p3_c0_busy", 32'(busy), 32'h1);
    check("p3_c0_func", 32'(func), 32'h000);
    tick();
    check("p3_c1_func", 32'(func), 32'(9'o123));
    check("p3_c1_pdi", 32'(proc_data_in), 32'h5A);
    check("p3_c1_rv", 32'(result_valid), 32'h0);
    tick();
    check("p3_c2_func", 32'(func), 32'(9'o210));
    check("p3_c2_rv", 32'(result_valid), 32'h0);
    tick();
    check("p3_c3_func", 32'(func), 32'(9'o301));
    check("p3_c3_rv", 32'(result_valid), 32'h0);
    check("p3_c3_busy", 32'(busy), 32'h1);
    tick();
    check("p3_c4_func", 32'(func), 32'h000);
    check("p3_c4_rv", 32'(result_valid), 32'h1);
    check("p3_c4_result", 32'(result), 32'hC3);
    check("p3_c4_done", 32'(done), 32'h1);
    check("p3_c4_busy", 32'(busy), 32'h0);
    tick();
    check("p3_c5_rv", 32'(result_valid), 32'h0);
    check("p3_c5_done", 32'(done), 32'h0);
    // zero-length run
    start = 1'b1; length = 5'd0;
    tick();
    start = 1'b0;
    check("z_done", 32'(done), 32'h1);
    check("z_busy", 32'(busy), 32'h0);
    check("z_func", 32'(func), 32'h000);
    tick();
    check("z_done_end", 32'(done), 32'h0);
    check("z_func_end", 32'(func), 32'h000);
    // over-length run is clamped to DEPTH
    for (int i = 0; i < 16; i++) load(4'(i), {1'b1, 9'(i + 1), 8'(i)});
    proc_data_out = 8'h3C;
    issues = 0; captures = 0; saw_done = 1'b0;
    start = 1'b1; length = 5'd21;
    tick();
    start = 1'b0;
    for (int c = 0; c < 40 && !saw_done; c++) begin
      tick();
      if (func != 9'h000) issues++;
      if (result_valid) captures++;
      saw_done = done;
    end
    check("clamp_done", 32'(saw_done), 32'h1);
    check("clamp_issues", 32'(issues), 32'd16);
    check("clamp_captures", 32'(captures), 32'd16);
    check("clamp_result", 32'(result), 32'h3C);
    tick();
    // load and start mid-run are ignored
    start = 1'b1; length = 5'd4;
    tick();
    start = 1'b0;
    tick();
    tick();
    load_en = 1'b1; load_addr = 4'd1; load_word = {1'b0, 9'o555, 8'hEE};
    start = 1'b1; length = 5'd2;
    tick();
    load_en = 1'b0; start = 1'b0;
    check("mid_func", 32'(func), 32'h003);
    check("mid_pdi", 32'(proc_data_in), 32'h02);
    tick();
    check("mid_last_func", 32'(func), 32'h004);
    check("mid_last_busy", 32'(busy), 32'h1);
    tick();
    check("mid_done", 32'(done), 32'h1);
    tick();
    // a load on the start edge is issued first
    load_en = 1'b1; load_addr = 4'd0; load_word = {1'b0, 9'o606, 8'h42};
    start = 1'b1; length = 5'd2;
    tick();
    load_en = 1'b0; start = 1'b0;
    tick();
    check("same_edge_func", 32'(func), 32'(9'o606));
    check("same_edge_pdi", 32'(proc_data_in), 32'h42);
    tick();
    check("unchanged_func", 32'(func), 32'h002);
    check("unchanged_pdi", 32'(proc_data_in), 32'h01);
    tick();
    tick();
    // reset on cycle 2 of a six-word run
    start = 1'b1; length = 5'd6;
    tick();
    start = 1'b0;
    tick();
    tick();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    check("abort_func", 32'(func), 32'h000);
    check("abort_busy", 32'(busy), 32'h0);
    check("abort_done", 32'(done), 32'h0);
    check("abort_rv", 32'(result_valid), 32'h0);
    for (int c = 0; c < 8; c++) begin
      tick();
      check("abort_quiet", {30'd0, done, result_valid}, 32'h0);
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
